// File: rtl/core_seq_if.sv
// core_seq_if: host, data-memory and core-control signal bundle for the
// core_seq run sequencer.
//
// Parameters:
//   AW  data memory address width, also the width of host_len
//   CW  cycle counter width
//
// Signals (direction as seen by core_seq through the slave modport):
//   host_start   in   start command
//   host_len     in   preload byte count, sampled with host_start
//   host_valid   in   preload byte valid
//   host_data    in   preload byte
//   host_ready   out  preload byte accepted when host_valid is also high
//   mem_wr_en    out  data memory write enable
//   mem_addr     out  data memory write address
//   mem_wr_data  out  data memory write data
//   core_reset   out  reset to the processor core
//   core_req     out  one-cycle start pulse to the processor core
//   core_done    in   core completion level
//   busy         out  sequencer is loading, holding the core or running
//   finished     out  run ended by core_done
//   timed_out    out  run ended by the watchdog
//   cycles       out  RUN cycle count
//
// The master modport is the host/core side; the slave modport is core_seq.
interface core_seq_if #(
  parameter int AW = 8,
  parameter int CW = 16
);
  logic          host_start;
  logic [AW-1:0] host_len;
  logic          host_valid;
  logic [7:0]    host_data;
  logic          host_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wr_data;
  logic          core_reset;
  logic          core_req;
  logic          core_done;
  logic          busy;
  logic          finished;
  logic          timed_out;
  logic [CW-1:0] cycles;

  modport master (
    output host_start, host_len, host_valid, host_data, core_done,
    input  host_ready, mem_wr_en, mem_addr, mem_wr_data,
           core_reset, core_req, busy, finished, timed_out, cycles
  );

  modport slave (
    input  host_start, host_len, host_valid, host_data, core_done,
    output host_ready, mem_wr_en, mem_addr, mem_wr_data,
           core_reset, core_req, busy, finished, timed_out, cycles
  );
endinterface

// File: rtl/core_seq.sv
// core_seq: run sequencer sitting in front of the processor core.
//
// A host start command preloads host_len bytes into data memory over a
// valid/ready byte stream, then the core is held in reset for two cycles,
// released with a one-cycle core_req pulse, and the sequencer counts RUN
// cycles until the core raises core_done. Completion status and the cycle
// count stay visible in DONE until the next start.
//
// Parameters:
//   AW       data memory address width and host_len width
//   CW       cycle counter width (counter saturates at all ones)
//   TIMEOUT  watchdog limit in RUN cycles (only present with SEQ_WATCHDOG_EN)
//
// Ports:
//   clk    in  single rising-edge clock
//   reset  in  synchronous active-high reset
//   bus    core_seq_if.slave, host stream, memory write port, core control
//          and status outputs
//
// Optional feature: define SEQ_WATCHDOG_EN to end a run with timed_out=1
// once cycles reaches TIMEOUT without core_done. Without it timed_out is
// constant 0 and RUN waits for core_done indefinitely.
module core_seq #(
  parameter int AW = 8,
  parameter int CW = 16
`ifdef SEQ_WATCHDOG_EN
  ,
  parameter int TIMEOUT = 4096
`endif
) (
  input  logic      clk,
  input  logic      reset,
  core_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CORE_RST,
    RUN,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_len;
  logic          r_rstCnt;
  logic [CW-1:0] r_cycles;
  logic          r_finished;
  logic          r_coreReset;
  logic          r_coreReq;
  logic          r_busy;

  logic          w_start;
  logic          w_accept;
  logic          w_lastByte;
  logic          w_finish;
  logic          w_timeout;

  // Qualified events: a start only counts in IDLE/DONE, a byte only in LOAD,
  // and core_done only in RUN. The watchdog yields to core_done on a tie.
  always_comb begin
    w_start    = bus.host_start && ((r_state == IDLE) || (r_state == DONE));
    w_accept   = (r_state == LOAD) && bus.host_valid;
    w_lastByte = w_accept && (r_addr == (r_len - 1'b1));
    w_finish   = (r_state == RUN) && bus.core_done;
`ifdef SEQ_WATCHDOG_EN
    w_timeout  = (r_state == RUN) && !bus.core_done &&
                 (r_cycles >= CW'(TIMEOUT));
`else
    w_timeout  = 1'b0;
`endif
  end

  // Next-state logic. A zero-length start skips LOAD entirely; CORE_RST
  // leaves after its second cycle, tracked by r_rstCnt.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_start) begin
          w_next = (bus.host_len != '0) ? LOAD : CORE_RST;
        end
      end
      LOAD: begin
        if (w_lastByte) begin
          w_next = CORE_RST;
        end
      end
      CORE_RST: begin
        if (r_rstCnt) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (w_finish || w_timeout) begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Memory write port is combinational so a byte is written in the same
  // cycle it is accepted; everything is quiet outside LOAD.
  assign bus.host_ready  = (r_state == LOAD);
  assign bus.mem_wr_en   = w_accept;
  assign bus.mem_addr    = (r_state == LOAD) ? r_addr : '0;
  assign bus.mem_wr_data = w_accept ? bus.host_data : 8'h00;

  assign bus.core_reset  = r_coreReset;
  assign bus.core_req    = r_coreReq;
  assign bus.busy        = r_busy;
  assign bus.finished    = r_finished;
  assign bus.cycles      = r_cycles;

  // State, counters and registered status. Status bits are computed from the
  // next state so they line up with the state they describe. The cycle
  // counter advances on every edge into RUN, so it reads 1 on the first RUN
  // cycle and holds its value once the run leaves RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_rstCnt    <= 1'b0;
      r_cycles    <= '0;
      r_finished  <= 1'b0;
      r_coreReset <= 1'b1;
      r_coreReq   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rstCnt    <= (r_state == CORE_RST) && !r_rstCnt;
      r_coreReset <= (w_next == IDLE) || (w_next == LOAD) ||
                     (w_next == CORE_RST);
      r_busy      <= (w_next == LOAD) || (w_next == CORE_RST) ||
                     (w_next == RUN);
      r_coreReq   <= (w_next == RUN) && (r_state != RUN);
      if (w_start) begin
        r_addr     <= '0;
        r_len      <= bus.host_len;
        r_cycles   <= '0;
        r_finished <= 1'b0;
      end else begin
        if (w_accept) begin
          r_addr <= r_addr + 1'b1;
        end
        if ((w_next == RUN) && (r_cycles != '1)) begin
          r_cycles <= r_cycles + 1'b1;
        end
        if (w_finish) begin
          r_finished <= 1'b1;
        end
      end
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic r_timedOut;

  // Watchdog status flag, cleared by an accepted start like the other status.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timedOut <= 1'b0;
    end else if (w_start) begin
      r_timedOut <= 1'b0;
    end else if (w_timeout) begin
      r_timedOut <= 1'b1;
    end
  end

  assign bus.timed_out = r_timedOut;
`else
  assign bus.timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: self-checking bench for core_seq.
//
// Memory writes are checked against a scoreboard: each preload byte pushes
// its expected address/data when driven, and a negedge monitor pops and
// compares every mem_wr_en pulse. Each test task checks its own status
// outputs inline. Inputs change 1 time unit after the rising edge and
// outputs are sampled there or on the falling edge.
module tb_core_seq;

  localparam int AW = 8;
  localparam int CW = 16;
`ifdef SEQ_WATCHDOG_EN
  localparam int TIMEOUT = 16;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  wr_t  sbQ[$];
  wr_t  monExp;

  core_seq_if #(.AW(AW), .CW(CW)) bus ();

  core_seq #(
    .AW(AW),
    .CW(CW)
`ifdef SEQ_WATCHDOG_EN
    ,
    .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every write must match the oldest expected byte.
  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                 bus.mem_addr, bus.mem_wr_data);
      end else begin
        monExp = sbQ.pop_front();
        if ((bus.mem_addr !== monExp.addr) || (bus.mem_wr_data !== monExp.data)) begin
          errors++;
          $display("[TB] FAIL mem_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   bus.mem_addr, bus.mem_wr_data, monExp.addr, monExp.data);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushExp(input logic [AW-1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sbQ.push_back(e);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset = 1'b1;
    bus.host_start = 1'b1;
    bus.host_len = 8'd3;
    step(2);
    reset = 1'b0;
    bus.host_start = 1'b0;
    bus.host_valid = 1'b1;
    bus.host_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.core_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_core_reset: got %b required 1", bus.core_reset); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", bus.busy); end
      checks++; if (bus.cycles !== 16'd0) begin errors++; $display("[TB] FAIL reset_cycles: got %0d required 0", bus.cycles); end
      checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_host_ready: got %b required 0", bus.host_ready); end
      checks++; if (bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 8'd0 || bus.mem_wr_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_mem: got en=%b addr=%0h data=%0h required 0 0 0", bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data); end
      checks++; if (bus.core_req !== 1'b0 || bus.finished !== 1'b0 || bus.timed_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_status: got req=%b fin=%b to=%b required 0 0 0", bus.core_req, bus.finished, bus.timed_out); end
      step();
    end
    bus.host_valid = 1'b0;
  endtask

  task automatic test_load_three();
    int reqs;
    $display("[TB] test_load_three");
    bus.host_start = 1'b1;
    bus.host_len = 8'd3;
    step();
    bus.host_start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.host_ready !== 1'b1 || bus.core_reset !== 1'b1) begin errors++; $display("[TB] FAIL load_entry: got busy=%b ready=%b core_reset=%b required 1 1 1", bus.busy, bus.host_ready, bus.core_reset); end
    pushExp(8'd0, 8'hA1);
    bus.host_valid = 1'b1; bus.host_data = 8'hA1;
    step();
    bus.host_valid = 1'b0;
    step();
    pushExp(8'd1, 8'hB2);
    bus.host_valid = 1'b1; bus.host_data = 8'hB2;
    step();
    pushExp(8'd2, 8'hC3);
    bus.host_data = 8'hC3;
    step();
    bus.host_valid = 1'b0;
    checks++; if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL load_writes_seen: got %0d pending required 0", sbQ.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.core_reset !== 1'b1 || bus.core_req !== 1'b0 || bus.host_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_core_rst: got core_reset=%b req=%b ready=%b required 1 0 0", bus.core_reset, bus.core_req, bus.host_ready); end
      step();
    end
    reqs = 0;
    checks++; if (bus.core_req !== 1'b1 || bus.core_reset !== 1'b0 || bus.cycles !== 16'd1) begin errors++; $display("[TB] FAIL load_run_entry: got req=%b core_reset=%b cycles=%0d required 1 0 1", bus.core_req, bus.core_reset, bus.cycles); end
    if (bus.core_req === 1'b1) reqs++;
    for (int n = 2; n <= 6; n++) begin
      step();
      if (bus.core_req === 1'b1) reqs++;
      checks++; if (bus.cycles !== CW'(n)) begin errors++; $display("[TB] FAIL load_run_cycles: got %0d required %0d", bus.cycles, n); end
    end
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
    checks++; if (reqs != 1) begin errors++; $display("[TB] FAIL load_req_pulses: got %0d required 1", reqs); end
    checks++; if (bus.finished !== 1'b1 || bus.cycles !== 16'd6 || bus.busy !== 1'b0 || bus.core_reset !== 1'b0) begin errors++; $display("[TB] FAIL load_done: got fin=%b cycles=%0d busy=%b core_reset=%b required 1 6 0 0", bus.finished, bus.cycles, bus.busy, bus.core_reset); end
    bus.core_done = 1'b1;
    step(2);
    bus.core_done = 1'b0;
    checks++; if (bus.finished !== 1'b1 || bus.cycles !== 16'd6 || bus.core_req !== 1'b0) begin errors++; $display("[TB] FAIL load_done_hold: got fin=%b cycles=%0d req=%b required 1 6 0", bus.finished, bus.cycles, bus.core_req); end
  endtask

  task automatic test_zero_len();
    $display("[TB] test_zero_len");
    bus.host_start = 1'b1;
    bus.host_len = 8'd0;
    bus.host_valid = 1'b1;
    bus.host_data = 8'hEE;
    step();
    bus.host_start = 1'b0;
    checks++; if (bus.finished !== 1'b0 || bus.cycles !== 16'd0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_cleared: got fin=%b cycles=%0d busy=%b required 0 0 1", bus.finished, bus.cycles, bus.busy); end
    checks++; if (bus.core_reset !== 1'b1 || bus.host_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_core_rst1: got core_reset=%b ready=%b required 1 0", bus.core_reset, bus.host_ready); end
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
    checks++; if (bus.core_reset !== 1'b1) begin errors++; $display("[TB] FAIL zero_core_rst2: got core_reset=%b required 1", bus.core_reset); end
    step();
    checks++; if (bus.core_reset !== 1'b0 || bus.core_req !== 1'b1 || bus.cycles !== 16'd1) begin errors++; $display("[TB] FAIL zero_run_entry: got core_reset=%b req=%b cycles=%0d required 0 1 1", bus.core_reset, bus.core_req, bus.cycles); end
    for (int n = 2; n <= 130; n++) begin
      step();
      bus.host_start = (n == 50);
      bus.host_len = 8'd5;
      checks++; if (bus.cycles !== CW'(n) || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_run_count: got cycles=%0d busy=%b required %0d 1", bus.cycles, bus.busy, n); end
    end
    bus.host_start = 1'b0;
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
    bus.host_valid = 1'b0;
    checks++; if (bus.finished !== 1'b1 || bus.cycles !== 16'd130 || bus.timed_out !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_done: got fin=%b cycles=%0d to=%b busy=%b required 1 130 0 0", bus.finished, bus.cycles, bus.timed_out, bus.busy); end
  endtask

  task automatic test_restart_from_done();
    $display("[TB] test_restart_from_done");
    bus.host_start = 1'b1;
    bus.host_len = 8'd0;
    step();
    bus.host_start = 1'b0;
    checks++; if (bus.finished !== 1'b0 || bus.cycles !== 16'd0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_cleared: got fin=%b cycles=%0d busy=%b required 0 0 1", bus.finished, bus.cycles, bus.busy); end
    step(2);
    checks++; if (bus.core_req !== 1'b1 || bus.cycles !== 16'd1) begin errors++; $display("[TB] FAIL restart_run: got req=%b cycles=%0d required 1 1", bus.core_req, bus.cycles); end
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
    checks++; if (bus.finished !== 1'b1 || bus.cycles !== 16'd1) begin errors++; $display("[TB] FAIL restart_done: got fin=%b cycles=%0d required 1 1", bus.finished, bus.cycles); end
  endtask

  task automatic test_reset_mid_load();
    $display("[TB] test_reset_mid_load");
    bus.host_start = 1'b1;
    bus.host_len = 8'd4;
    step();
    bus.host_start = 1'b0;
    pushExp(8'd0, 8'h11);
    bus.host_valid = 1'b1; bus.host_data = 8'h11;
    step();
    bus.host_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.core_reset !== 1'b1 || bus.host_ready !== 1'b0 || bus.finished !== 1'b0) begin errors++; $display("[TB] FAIL midload_reset: got busy=%b core_reset=%b ready=%b fin=%b required 0 1 0 0", bus.busy, bus.core_reset, bus.host_ready, bus.finished); end
    bus.host_valid = 1'b1; bus.host_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL midload_no_write: got %b required 0", bus.mem_wr_en); end
      step();
    end
    bus.host_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    bus.host_start = 1'b1;
    bus.host_len = 8'd2;
    step();
    bus.host_start = 1'b0;
    pushExp(8'd0, 8'h3C);
    bus.host_valid = 1'b1; bus.host_data = 8'h3C;
    step();
    pushExp(8'd1, 8'hC3);
    bus.host_data = 8'hC3;
    step();
    bus.host_valid = 1'b0;
    checks++; if (sbQ.size() != 0 || bus.host_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_load: got pending=%0d ready=%b busy=%b required 0 0 1", sbQ.size(), bus.host_ready, bus.busy); end
    step(2);
    checks++; if (bus.core_req !== 1'b1 || bus.core_reset !== 1'b0) begin errors++; $display("[TB] FAIL b2b_run: got req=%b core_reset=%b required 1 0", bus.core_req, bus.core_reset); end
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
    checks++; if (bus.finished !== 1'b1 || bus.cycles !== 16'd1) begin errors++; $display("[TB] FAIL b2b_done: got fin=%b cycles=%0d required 1 1", bus.finished, bus.cycles); end
  endtask

  task automatic test_watchdog();
    $display("[TB] test_watchdog");
    bus.host_start = 1'b1;
    bus.host_len = 8'd0;
    step();
    bus.host_start = 1'b0;
    step(2);
`ifdef SEQ_WATCHDOG_EN
    step(TIMEOUT - 1);
    checks++; if (bus.cycles !== CW'(TIMEOUT) || bus.timed_out !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL wd_last_run: got cycles=%0d to=%b busy=%b required %0d 0 1", bus.cycles, bus.timed_out, bus.busy, TIMEOUT); end
    step();
    checks++; if (bus.timed_out !== 1'b1 || bus.finished !== 1'b0 || bus.cycles !== CW'(TIMEOUT) || bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL wd_timeout: got to=%b fin=%b cycles=%0d busy=%b required 1 0 %0d 0", bus.timed_out, bus.finished, bus.cycles, bus.busy, TIMEOUT); end
    step(3);
    checks++; if (bus.timed_out !== 1'b1 || bus.cycles !== CW'(TIMEOUT)) begin errors++; $display("[TB] FAIL wd_hold: got to=%b cycles=%0d required 1 %0d", bus.timed_out, bus.cycles, TIMEOUT); end
    bus.host_start = 1'b1;
    step();
    bus.host_start = 1'b0;
    checks++; if (bus.timed_out !== 1'b0) begin errors++; $display("[TB] FAIL wd_clear: got %b required 0", bus.timed_out); end
    step(2 + TIMEOUT - 1);
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
    checks++; if (bus.finished !== 1'b1 || bus.timed_out !== 1'b0 || bus.cycles !== CW'(TIMEOUT)) begin errors++; $display("[TB] FAIL wd_tie: got fin=%b to=%b cycles=%0d required 1 0 %0d", bus.finished, bus.timed_out, bus.cycles, TIMEOUT); end
`else
    step(1100);
    checks++; if (bus.busy !== 1'b1 || bus.timed_out !== 1'b0 || bus.finished !== 1'b0 || bus.core_reset !== 1'b0) begin errors++; $display("[TB] FAIL nowd_still_run: got busy=%b to=%b fin=%b core_reset=%b required 1 0 0 0", bus.busy, bus.timed_out, bus.finished, bus.core_reset); end
    checks++; if (bus.cycles !== 16'd1101) begin errors++; $display("[TB] FAIL nowd_cycles: got %0d required 1101", bus.cycles); end
    bus.core_done = 1'b1;
    step();
    bus.core_done = 1'b0;
    checks++; if (bus.finished !== 1'b1 || bus.cycles !== 16'd1101) begin errors++; $display("[TB] FAIL nowd_done: got fin=%b cycles=%0d required 1 1101", bus.finished, bus.cycles); end
`endif
  endtask

  // Test sequence; each task leaves the DUT in IDLE or DONE for the next.
  initial begin
    reset = 1'b1;
    bus.host_start = 1'b0;
    bus.host_len = '0;
    bus.host_valid = 1'b0;
    bus.host_data = 8'h00;
    bus.core_done = 1'b0;
    test_reset();
    test_load_three();
    test_zero_len();
    test_restart_from_done();
    test_reset_mid_load();
    test_back_to_back();
    test_watchdog();
    step(2);
    checks++; if (sbQ.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drained: got %0d pending required 0", sbQ.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Run sequencer that sits directly upstream of the processor core. It takes a host start command and preloads `host_len` bytes into data memory through a byte-stream handshake. It then holds the core in reset, releases it with a one-cycle `req` pulse, and waits for the core's `done`. It reports completion, the cycle count and an optional watchdog timeout back to the host.

## Interface
- `AW`, 8: data memory address width; also the width of `host_len`.
- `CW`, 16: cycle counter width.
- `TIMEOUT`, 4096: watchdog limit in RUN cycles; only used when `SEQ_WATCHDOG_EN` is defined.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `host_start`  in  1  start command; accepted only in IDLE or DONE.
- `host_len`  in  AW  number of bytes to preload; sampled with `host_start`.
- `host_valid`  in  1  preload byte valid.
- `host_data`  in  8  preload byte.
- `host_ready`  out  1  preload byte accepted this cycle when `host_valid` is also high.
- `mem_wr_en`  out  1  data memory write enable.
- `mem_addr`  out  AW  data memory write address.
- `mem_wr_data`  out  8  data memory write data.
- `core_reset`  out  1  drives the core's `reset`.
- `core_req`  out  1  drives the core's `req`; one-cycle pulse.
- `core_done`  in  1  core's `done`; level.
- `busy`  out  1  high in LOAD, CORE_RST and RUN.
- `finished`  out  1  run ended by `core_done`.
- `timed_out`  out  1  run ended by the watchdog.
- `cycles`  out  CW  RUN cycle count.

## Operation
- States: IDLE, LOAD, CORE_RST, RUN, DONE.
- IDLE / DONE with `host_start`=1:
  - Clear the address counter, `cycles`, `finished` and `timed_out`.
  - Latch `host_len`.
  - Go to LOAD if `host_len`≠0, otherwise go to CORE_RST.
- LOAD:
  - `host_ready`=1.
  - On `host_valid`&`host_ready`, the same cycle drives `mem_wr_en`=1, `mem_addr`=address counter and `mem_wr_data`=`host_data`; the counter then increments.
  - After the byte at address `len`-1 is accepted, go to CORE_RST.
  - Gaps in `host_valid` are allowed.
- CORE_RST: dwell exactly 2 cycles, then go to RUN.
- RUN:
  - `core_req`=1 on the first RUN cycle only.
  - `cycles` increments every RUN cycle and saturates at 2^CW−1.
  - `core_done` sampled at 1 → DONE with `finished`=1.
- DONE: status outputs and `cycles` hold until the next accepted `host_start`.
- `core_reset`:
  - High in IDLE, LOAD and CORE_RST.
  - Low in RUN and DONE, so core state stays observable after the run.
- `host_start` in LOAD, CORE_RST or RUN is ignored.
- `core_done` outside RUN is ignored.
- `host_valid` outside LOAD is ignored and not acknowledged.
- `mem_wr_en`=0 in every state other than LOAD.

## Timing
- Reset values:
  - state IDLE; `core_reset`=1.
  - `core_req`, `host_ready`, `mem_wr_en`, `busy`, `finished`, `timed_out` all 0.
  - `mem_addr`=0, `mem_wr_data`=0, `cycles`=0.
- Reset mid-operation returns to IDLE within one cycle. Any partial preload is abandoned and the core is held in reset.
- `host_ready`, `mem_wr_en`, `mem_addr` and `mem_wr_data` are combinational from state, the counter and `host_valid`. All status outputs are registered.
- Latency:
  - Accepted `host_start` → first LOAD cycle: 1 cycle.
  - Last byte accepted → RUN entry: 3 cycles (1 transition plus 2 CORE_RST).
  - `host_len`=0: start → RUN entry is 3 cycles.
- `cycles` counts from 1 on the first RUN cycle. A `core_done` seen on RUN cycle N leaves `cycles`=N, and `finished` rises the next cycle.
- `host_start` coincident with `reset`: reset wins.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - When `cycles` reaches `TIMEOUT` in RUN without `core_done`, go to DONE with `timed_out`=1.
  - If `core_done` arrives on the same cycle, `finished` takes priority and `timed_out` stays 0.
- Not defined: `timed_out` is tied to 0 and RUN waits indefinitely for `core_done`.

## Test plan
- Reset, then idle 5 cycles → `core_reset`=1, `busy`=0, `cycles`=0, no `mem_wr_en`.
- `host_start`, `host_len`=3, bytes 0xA1, 0xB2, 0xC3 with one idle gap → writes at addresses 0, 1, 2 with those data; RUN entered 3 cycles after the last byte; `core_req` pulses exactly once.
- `host_len`=0 → no writes; `core_reset` falls 3 cycles after start; `core_done` on RUN cycle 130 → `cycles`=130, `finished`=1.
- `host_start` pulsed during RUN → ignored, and counting continues; `host_start` in DONE → status cleared and a new run begins.
- Reset asserted mid-LOAD after 1 of 4 bytes → IDLE, `core_reset`=1, no further writes.
- With `SEQ_WATCHDOG_EN` and `TIMEOUT`=16, `core_done` held 0 → `timed_out`=1 with `cycles`=16. Without the macro, RUN persists past 1000 cycles.
